// File: rtl/dff_vr_pipe.sv
// Valid/ready pipeline register chain of DEPTH stages with bubble collapsing,
// synchronous flush and asynchronous active-high reset.
module dff_vr_pipe #(
  parameter int unsigned   DW      = 32,
  parameter int unsigned   DEPTH   = 2,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [DW-1:0]              i_dat,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [DW-1:0]              o_dat,
  output logic [$clog2(DEPTH+1)-1:0] o_cnt
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DW-1:0]    d [DEPTH];
  logic             accept;

  // The recursive adv chain unrolls to: slot k moves when it is valid and either
  // o_ready is high or some later slot is empty. Scanning from the output slot
  // with a running OR avoids a self-referencing combinational vector.
  always_comb begin : adv_chain
    logic go;
    go  = o_ready;
    adv = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      adv[DEPTH-1-j] = v[DEPTH-1-j] & go;
      go             = go | ~v[DEPTH-1-j];
    end
  end

  assign i_ready = ~flush & (~v[0] | adv[0]);
  assign accept  = i_valid & i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        d[k] <= RST_VAL;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      if (accept) begin
        v[0] <= 1'b1;
        d[0] <= i_dat;
      end else if (adv[0]) begin
        v[0] <= 1'b0;
      end
      for (int unsigned k = 1; k < DEPTH; k++) begin
        if (adv[k-1]) begin
          v[k] <= 1'b1;
          d[k] <= d[k-1];
        end else if (adv[k]) begin
          v[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    o_cnt = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      o_cnt = o_cnt + CW'(v[k]);
    end
  end

  assign o_valid = v[DEPTH-1];
  assign o_dat   = d[DEPTH-1];

`ifndef FPGA
  x_check: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({i_valid, o_ready, flush}));
`endif

endmodule

// File: tb/tb_dff_vr_pipe.sv
// Directed bench for dff_vr_pipe: one DEPTH=2 and one DEPTH=3 instance, DW=8.
module tb_dff_vr_pipe;

  localparam logic [7:0] RV = 8'h5A;

  logic       clk, rst;
  logic       u2_flush, u2_i_valid, u2_i_ready, u2_o_valid, u2_o_ready;
  logic [7:0] u2_i_dat, u2_o_dat;
  logic [1:0] u2_o_cnt;
  logic       u3_flush, u3_i_valid, u3_i_ready, u3_o_valid, u3_o_ready;
  logic [7:0] u3_i_dat, u3_o_dat;
  logic [1:0] u3_o_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  dff_vr_pipe #(.DW(8), .DEPTH(2), .RST_VAL(RV)) u2 (
    .clk(clk), .rst(rst), .flush(u2_flush),
    .i_valid(u2_i_valid), .i_ready(u2_i_ready), .i_dat(u2_i_dat),
    .o_valid(u2_o_valid), .o_ready(u2_o_ready), .o_dat(u2_o_dat),
    .o_cnt(u2_o_cnt)
  );

  dff_vr_pipe #(.DW(8), .DEPTH(3), .RST_VAL(RV)) u3 (
    .clk(clk), .rst(rst), .flush(u3_flush),
    .i_valid(u3_i_valid), .i_ready(u3_i_ready), .i_dat(u3_i_dat),
    .o_valid(u3_o_valid), .o_ready(u3_o_ready), .o_dat(u3_o_dat),
    .o_cnt(u3_o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    total_cnt++; if (u2_o_valid !== 1'b0) $display("FAIL rst_valid2: got %b want 0", u2_o_valid); else pass_cnt++;
    total_cnt++; if (u2_o_dat !== RV) $display("FAIL rst_dat2: got %h want %h", u2_o_dat, RV); else pass_cnt++;
    total_cnt++; if (u3_o_dat !== RV) $display("FAIL rst_dat3: got %h want %h", u3_o_dat, RV); else pass_cnt++;
    total_cnt++; if (u3_o_cnt !== 2'd0) $display("FAIL rst_cnt3: got %0d want 0", u3_o_cnt); else pass_cnt++;
    total_cnt++; if (u2_i_ready !== 1'b1) $display("FAIL rst_ready2: got %b want 1", u2_i_ready); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    u3_o_ready = 1'b1;
    u3_i_valid = 1'b1;
    u3_i_dat   = 8'hA1;
    tick();
    u3_i_valid = 1'b0;
    #1;
    total_cnt++; if (u3_o_valid !== 1'b0) $display("FAIL lat_e0: got %b want 0", u3_o_valid); else pass_cnt++;
    tick();
    total_cnt++; if (u3_o_valid !== 1'b0) $display("FAIL lat_e1: got %b want 0", u3_o_valid); else pass_cnt++;
    tick();
    total_cnt++; if (u3_o_valid !== 1'b1) $display("FAIL lat_e2_valid: got %b want 1", u3_o_valid); else pass_cnt++;
    total_cnt++; if (u3_o_dat !== 8'hA1) $display("FAIL lat_e2_dat: got %h want a1", u3_o_dat); else pass_cnt++;
    tick();
    total_cnt++; if (u3_o_valid !== 1'b0) $display("FAIL lat_pop_valid: got %b want 0", u3_o_valid); else pass_cnt++;
    total_cnt++; if (u3_o_dat !== 8'hA1) $display("FAIL lat_hold_dat: got %h want a1", u3_o_dat); else pass_cnt++;
    total_cnt++; if (u3_o_cnt !== 2'd0) $display("FAIL lat_cnt: got %0d want 0", u3_o_cnt); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    u2_o_ready = 1'b0;
    u2_i_valid = 1'b1;
    u2_i_dat   = 8'h11;
    #1;
    total_cnt++; if (u2_i_ready !== 1'b1) $display("FAIL bp_rdy0: got %b want 1", u2_i_ready); else pass_cnt++;
    tick();
    u2_i_dat = 8'h22;
    #1;
    total_cnt++; if (u2_i_ready !== 1'b1) $display("FAIL bp_rdy1: got %b want 1", u2_i_ready); else pass_cnt++;
    tick();
    u2_i_dat = 8'h33;
    #1;
    total_cnt++; if (u2_i_ready !== 1'b0) $display("FAIL bp_rdy_full: got %b want 0", u2_i_ready); else pass_cnt++;
    total_cnt++; if (u2_o_cnt !== 2'd2) $display("FAIL bp_cnt_full: got %0d want 2", u2_o_cnt); else pass_cnt++;
    tick();
    total_cnt++; if (u2_o_cnt !== 2'd2) $display("FAIL bp_cnt_stall: got %0d want 2", u2_o_cnt); else pass_cnt++;
    total_cnt++; if (u2_o_dat !== 8'h11) $display("FAIL bp_dat_stall: got %h want 11", u2_o_dat); else pass_cnt++;
    u2_o_ready = 1'b1;
    #1;
    total_cnt++; if (u2_i_ready !== 1'b1) $display("FAIL bp_rdy_release: got %b want 1", u2_i_ready); else pass_cnt++;
    tick();
    u2_i_valid = 1'b0;
    total_cnt++; if (u2_o_valid !== 1'b1 || u2_o_dat !== 8'h22) $display("FAIL bp_out22: got %b/%h want 1/22", u2_o_valid, u2_o_dat); else pass_cnt++;
    tick();
    total_cnt++; if (u2_o_valid !== 1'b1 || u2_o_dat !== 8'h33) $display("FAIL bp_out33: got %b/%h want 1/33", u2_o_valid, u2_o_dat); else pass_cnt++;
    tick();
    total_cnt++; if (u2_o_valid !== 1'b0 || u2_o_cnt !== 2'd0) $display("FAIL bp_empty: got %b/%0d want 0/0", u2_o_valid, u2_o_cnt); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    u2_o_ready = 1'b0;
    u2_i_valid = 1'b1;
    u2_i_dat   = 8'h77;
    tick();
    u2_i_dat = 8'h88;
    tick();
    u2_i_valid = 1'b0;
    total_cnt++; if (u2_o_cnt !== 2'd2 || u2_o_dat !== 8'h77) $display("FAIL mr_pre: got %0d/%h want 2/77", u2_o_cnt, u2_o_dat); else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++; if (u2_o_valid !== 1'b0) $display("FAIL mr_valid: got %b want 0", u2_o_valid); else pass_cnt++;
    total_cnt++; if (u2_o_dat !== RV) $display("FAIL mr_dat: got %h want %h", u2_o_dat, RV); else pass_cnt++;
    total_cnt++; if (u2_o_cnt !== 2'd0) $display("FAIL mr_cnt: got %0d want 0", u2_o_cnt); else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total_cnt++; if (u2_i_ready !== 1'b1) $display("FAIL mr_ready: got %b want 1", u2_i_ready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    u3_o_ready = 1'b0;
    u3_i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      u3_i_dat = 8'h40 + 8'(i);
      tick();
    end
    total_cnt++; if (u3_o_cnt !== 2'd3 || u3_i_ready !== 1'b0) $display("FAIL b2b_full: got %0d/%b want 3/0", u3_o_cnt, u3_i_ready); else pass_cnt++;
    u3_o_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      u3_i_dat = 8'h43 + 8'(i);
      #1;
      total_cnt++;
      if (u3_o_valid !== 1'b1 || u3_o_dat !== 8'h40 + 8'(i) || u3_i_ready !== 1'b1 || u3_o_cnt !== 2'd3)
        $display("FAIL b2b_%0d: got v%b d%h r%b c%0d want v1 d%h r1 c3",
                 i, u3_o_valid, u3_o_dat, u3_i_ready, u3_o_cnt, 8'h40 + 8'(i));
      else pass_cnt++;
      tick();
    end
    u3_i_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (u3_o_valid !== 1'b1 || u3_o_dat !== 8'h4A + 8'(i))
        $display("FAIL b2b_drain_%0d: got %b/%h want 1/%h", i, u3_o_valid, u3_o_dat, 8'h4A + 8'(i));
      else pass_cnt++;
      tick();
    end
    total_cnt++; if (u3_o_cnt !== 2'd0) $display("FAIL b2b_empty: got %0d want 0", u3_o_cnt); else pass_cnt++;
  endtask

  task automatic test_bubble();
    u3_o_ready = 1'b0;
    u3_i_valid = 1'b1;
    u3_i_dat   = 8'hB1;
    tick();
    u3_i_valid = 1'b0;
    tick();
    u3_i_valid = 1'b1;
    u3_i_dat   = 8'hB2;
    tick();
    u3_i_valid = 1'b0;
    #1;
    total_cnt++; if (u3_o_cnt !== 2'd2 || u3_o_dat !== 8'hB1) $display("FAIL bub_pre: got %0d/%h want 2/b1", u3_o_cnt, u3_o_dat); else pass_cnt++;
    tick();
    total_cnt++; if (u3_o_cnt !== 2'd2 || u3_i_ready !== 1'b1) $display("FAIL bub_collapse: got %0d/%b want 2/1", u3_o_cnt, u3_i_ready); else pass_cnt++;
    u3_i_valid = 1'b1;
    u3_i_dat   = 8'hB3;
    tick();
    u3_i_valid = 1'b0;
    #1;
    total_cnt++; if (u3_o_cnt !== 2'd3 || u3_i_ready !== 1'b0) $display("FAIL bub_full: got %0d/%b want 3/0", u3_o_cnt, u3_i_ready); else pass_cnt++;
    u3_o_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (u3_o_valid !== 1'b1 || u3_o_dat !== 8'hB1 + 8'(i))
        $display("FAIL bub_order_%0d: got %b/%h want 1/%h", i, u3_o_valid, u3_o_dat, 8'hB1 + 8'(i));
      else pass_cnt++;
      tick();
    end
    total_cnt++; if (u3_o_valid !== 1'b0) $display("FAIL bub_empty: got %b want 0", u3_o_valid); else pass_cnt++;
  endtask

  task automatic test_flush();
    u3_o_ready = 1'b0;
    u3_i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      u3_i_dat = 8'h61 + 8'(i);
      tick();
    end
    u3_o_ready = 1'b1;
    u3_i_dat   = 8'h64;
    u3_flush   = 1'b1;
    #1;
    total_cnt++; if (u3_i_ready !== 1'b0) $display("FAIL fl_ready: got %b want 0", u3_i_ready); else pass_cnt++;
    total_cnt++; if (u3_o_valid !== 1'b1 || u3_o_dat !== 8'h61) $display("FAIL fl_pre_out: got %b/%h want 1/61", u3_o_valid, u3_o_dat); else pass_cnt++;
    tick();
    u3_flush   = 1'b0;
    u3_i_valid = 1'b0;
    u3_o_ready = 1'b0;
    #1;
    total_cnt++; if (u3_o_valid !== 1'b0 || u3_o_cnt !== 2'd0) $display("FAIL fl_clear: got %b/%0d want 0/0", u3_o_valid, u3_o_cnt); else pass_cnt++;
    total_cnt++; if (u3_i_ready !== 1'b1) $display("FAIL fl_ready_after: got %b want 1", u3_i_ready); else pass_cnt++;
    total_cnt++; if (u3_o_dat !== 8'h61) $display("FAIL fl_dat_hold: got %h want 61", u3_o_dat); else pass_cnt++;
    u3_o_ready = 1'b1;
    u3_i_valid = 1'b1;
    u3_i_dat   = 8'h70;
    tick();
    u3_i_valid = 1'b0;
    tick();
    tick();
    total_cnt++; if (u3_o_valid !== 1'b1 || u3_o_dat !== 8'h70) $display("FAIL fl_reuse: got %b/%h want 1/70", u3_o_valid, u3_o_dat); else pass_cnt++;
  endtask

  initial begin
    rst        = 1'b1;
    u2_flush   = 1'b0; u2_i_valid = 1'b0; u2_o_ready = 1'b0; u2_i_dat = '0;
    u3_flush   = 1'b0; u3_i_valid = 1'b0; u3_o_ready = 1'b0; u3_i_dat = '0;
    test_reset();
    test_latency();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    test_bubble();
    test_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
